// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: two-port round-robin fetch arbiter that assembles
// 32-bit big-endian words from a byte-wide synchronous instruction memory.
module imem_fetch_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [31:0]           req0_addr,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [31:0]           rsp0_data,
  input  logic                  req1_valid,
  input  logic [31:0]           req1_addr,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [31:0]           rsp1_data,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  port;
  logic                  last_grant;
  logic                  rd_pend;
  logic [1:0]            rd_off;
  logic                  gnt0;
  logic                  gnt1;
  logic                  accept;
  logic [31:0]           sel_addr;
  logic [31:0]           cap_word;
  logic                  unused_addr;

  // On a tie the port that did not win last time gets the grant.
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);
  assign gnt0 = req0_valid & ~gnt1;
  assign accept = (state == IDLE) & (gnt0 | gnt1);

  assign sel_addr = gnt1 ? req1_addr : req0_addr;
  assign unused_addr = ^{sel_addr[31:ADDR_WIDTH], sel_addr[1:0]};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    unique case (state)
      IDLE: begin
        req0_ready = rst & gnt0;
        req1_ready = rst & gnt1;
        if (gnt0 | gnt1) begin
          state_nxt = READ;
        end
      end
      READ: begin
        mem_en   = 1'b1;
        mem_addr = base + ADDR_WIDTH'(cnt);
        if (cnt == 2'd3) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~port;
        rsp1_valid = port;
        if (port ? rsp1_ready : rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 2'd0;
      base       <= '0;
      port       <= 1'b0;
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_off     <= 2'd0;
    end else begin
      // Memory data lags the strobe by one cycle; track what is in flight.
      rd_pend <= mem_en;
      rd_off  <= cnt;
      if (accept) begin
        base       <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
        port       <= gnt1;
        last_grant <= gnt1;
        cnt        <= 2'd0;
      end else if (state == READ) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  always_comb begin
    cap_word = port ? rsp1_data : rsp0_data;
    unique case (rd_off)
      2'd0: cap_word[31:24] = mem_rdata;
      2'd1: cap_word[23:16] = mem_rdata;
      2'd2: cap_word[15:8]  = mem_rdata;
      2'd3: cap_word[7:0]   = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else if (rd_pend) begin
      if (port) begin
        rsp1_data <= cap_word;
      end else begin
        rsp0_data <= cap_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: scoreboard bench for the fetch arbiter with a
// byte-wide synchronous memory model.
module tb_imem_fetch_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0;
  logic [31:0]   req0_addr = '0;
  logic          req0_ready;
  logic          rsp0_valid;
  logic          rsp0_ready = 1'b0;
  logic [31:0]   rsp0_data;
  logic          req1_valid = 1'b0;
  logic [31:0]   req1_addr = '0;
  logic          req1_ready;
  logic          rsp1_valid;
  logic          rsp1_ready = 1'b0;
  logic [31:0]   rsp1_data;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          busy;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mem [1<<AW];

  imem_fetch_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_addr(req0_addr),
    .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data),
    .req1_valid(req1_valid),
    .req1_addr(req1_addr),
    .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr] : 8'hA5;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [AW-1:0] b;
    b = {a[AW-1:2], 2'b00};
    return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
  endfunction

  // Expected word is fixed at the accepting edge from the address seen there.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (req0_valid && req0_ready) begin
        e.data = exp_word(req0_addr);
        e.acc  = cyc + 1;
        q0.push_back(e);
      end
      if (req1_valid && req1_ready) begin
        e.data = exp_word(req1_addr);
        e.acc  = cyc + 1;
        q1.push_back(e);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    q0.delete();
    q1.delete();
    rst = 1'b1;
  endtask

  task automatic wait_hs(input int p, input int lim, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk);
      if (p == 0 && req0_valid && req0_ready) ok = 1'b1;
      if (p == 1 && req1_valid && req1_ready) ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int p, input int lim, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk);
      if (p == 0 && rsp0_valid) ok = 1'b1;
      if (p == 1 && rsp1_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit   ok;
    exp_t e;
    rst = 1'b0;
    req0_addr = 32'h10;
    req1_addr = 32'h04;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b exp 000000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, busy});
    end
    checks++;
    if (mem_addr !== '0 || rsp0_data !== '0 || rsp1_data !== '0) begin
      failures++;
      $display("FAIL reset_data: addr %h d0 %h d1 %h exp 0", mem_addr, rsp0_data, rsp1_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_tie: ready0 %b ready1 %b exp 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(0, 10, ok);
    checks++;
    if (!ok || q0.size() == 0) begin
      failures++;
      $display("FAIL reset_first_rsp: seen %b queued %0d exp 1 1", ok, q0.size());
    end else begin
      e = q0.pop_front();
      if (rsp0_data !== e.data) begin
        failures++;
        $display("FAIL reset_first_data: got %h exp %h", rsp0_data, e.data);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] addrs [3];
    bit          ok;
    bit          seen;
    int          n_en;
    exp_t        e;
    addrs[0] = 32'h0000_0010;
    addrs[1] = 32'h0000_0013;
    addrs[2] = 32'hFFFF_FC10;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      rsp0_ready = 1'b1;
      req0_addr = addrs[t];
      req0_valid = 1'b1;
      wait_hs(0, 10, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL single_accept[%0d]: no handshake exp handshake", t);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req0_addr = 32'hDEAD_BEEF;
      n_en = 0;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        if (mem_en) begin
          checks++;
          if (mem_addr !== AW'(32'h10 + n_en)) begin
            failures++;
            $display("FAIL single_addr[%0d.%0d]: got %h exp %h", t, n_en, mem_addr,
                     AW'(32'h10 + n_en));
          end
          n_en++;
        end
        if (rsp1_valid) begin
          checks++;
          failures++;
          $display("FAIL single_wrong_port[%0d]: rsp1_valid 1 exp 0", t);
        end
        if (rsp0_valid) seen = 1'b1;
      end
      checks++;
      if (n_en != 4) begin
        failures++;
        $display("FAIL single_nbytes[%0d]: got %0d exp 4", t, n_en);
      end
      checks++;
      if (!seen || q0.size() == 0) begin
        failures++;
        $display("FAIL single_rsp[%0d]: seen %b queued %0d exp 1 1", t, seen, q0.size());
      end else begin
        e = q0.pop_front();
        if (rsp0_data !== 32'h1305_5000 || rsp0_data !== e.data) begin
          failures++;
          $display("FAIL single_data[%0d]: got %h exp 13055000", t, rsp0_data);
        end
        checks++;
        if (cyc - e.acc != 5) begin
          failures++;
          $display("FAIL single_latency[%0d]: got %0d exp 5", t, cyc - e.acc);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit   exp_p;
    int   ng;
    int   nr;
    int   last_acc;
    exp_t e;
    do_reset();
    req0_addr = 32'h00;
    req1_addr = 32'h04;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    exp_p = 1'b0;
    ng = 0;
    nr = 0;
    last_acc = -1;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        checks++;
        failures++;
        $display("FAIL rr_double_ready: both ready exp one");
      end
      if (rsp0_valid && rsp1_valid) begin
        checks++;
        failures++;
        $display("FAIL rr_double_rsp: both valid exp one");
      end
      if (rsp0_valid) begin
        checks++;
        nr++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL rr_rsp0: unexpected response exp none");
        end else begin
          e = q0.pop_front();
          if (rsp0_data !== e.data) begin
            failures++;
            $display("FAIL rr_data0: got %h exp %h", rsp0_data, e.data);
          end
        end
      end
      if (rsp1_valid) begin
        checks++;
        nr++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL rr_rsp1: unexpected response exp none");
        end else begin
          e = q1.pop_front();
          if (rsp1_data !== e.data) begin
            failures++;
            $display("FAIL rr_data1: got %h exp %h", rsp1_data, e.data);
          end
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        checks++;
        if (req1_ready !== exp_p) begin
          failures++;
          $display("FAIL rr_order[%0d]: got port %b exp %b", ng, req1_ready, exp_p);
        end
        if (last_acc >= 0) begin
          checks++;
          if (cyc + 1 - last_acc != 7) begin
            failures++;
            $display("FAIL rr_interval[%0d]: got %0d exp 7", ng, cyc + 1 - last_acc);
          end
        end
        last_acc = cyc + 1;
        exp_p = ~exp_p;
        ng++;
        if (ng == 4) begin
          @(posedge clk); #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    checks++;
    if (nr != 4) begin
      failures++;
      $display("FAIL rr_count: got %0d responses exp 4", nr);
    end
  endtask

  task automatic test_stall();
    bit   ok;
    exp_t e;
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b0;
    req1_addr = 32'h20;
    req1_valid = 1'b1;
    wait_hs(1, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_accept: no handshake exp handshake");
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_addr = 32'h08;
    req0_valid = 1'b1;
    wait_rsp(1, 10, ok);
    checks++;
    if (!ok || q1.size() == 0) begin
      failures++;
      $display("FAIL stall_rsp: seen %b queued %0d exp 1 1", ok, q1.size());
    end else begin
      e = q1[0];
      for (int c = 0; c < 10; c++) begin
        if (c > 0) @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== e.data || mem_en !== 1'b0 ||
            req0_ready !== 1'b0 || rsp0_valid !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold[%0d]: v1 %b d1 %h en %b r0 %b v0 %b busy %b exp 1 %h 0 0 0 1",
                   c, rsp1_valid, rsp1_data, mem_en, req0_ready, rsp0_valid, busy, e.data);
        end
      end
      @(posedge clk); #1;
      rsp1_ready = 1'b1;
      @(negedge clk);
      checks++;
      e = q1.pop_front();
      if (rsp1_valid !== 1'b1 || rsp1_data !== e.data) begin
        failures++;
        $display("FAIL stall_release: v1 %b d1 %h exp 1 %h", rsp1_valid, rsp1_data, e.data);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_idle: busy %b r0 %b v1 %b exp 0 1 0", busy, req0_ready, rsp1_valid);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(0, 10, ok);
    checks++;
    if (!ok || q0.size() == 0) begin
      failures++;
      $display("FAIL stall_pending: seen %b queued %0d exp 1 1", ok, q0.size());
    end else begin
      e = q0.pop_front();
      if (rsp0_data !== e.data || rsp1_data !== exp_word(32'h20)) begin
        failures++;
        $display("FAIL stall_pending_data: d0 %h d1 %h exp %h %h", rsp0_data, rsp1_data,
                 e.data, exp_word(32'h20));
      end
    end
  endtask

  task automatic test_reset_abort();
    bit   ok;
    int   bad;
    exp_t e;
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    req0_addr = 32'h10;
    req0_valid = 1'b1;
    wait_hs(0, 10, ok);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || mem_en !== 1'b1 || mem_addr !== AW'(32'h12)) begin
      failures++;
      $display("FAIL abort_setup: en %b addr %h exp 1 012", mem_en, mem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, busy} !== 6'b0 ||
        mem_addr !== '0 || rsp0_data !== '0 || rsp1_data !== '0) begin
      failures++;
      $display("FAIL abort_outputs: ctl %b addr %h d0 %h d1 %h exp all 0",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, busy},
               mem_addr, rsp0_data, rsp1_data);
    end
    q0.delete();
    req0_addr = 32'h04;
    req0_valid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || req0_ready || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_held: got %0d active cycles exp 0", bad);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_reaccept: ready0 %b exp 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(0, 10, ok);
    checks++;
    if (!ok || q0.size() == 0) begin
      failures++;
      $display("FAIL abort_rsp: seen %b queued %0d exp 1 1", ok, q0.size());
    end else begin
      e = q0.pop_front();
      if (rsp0_data !== e.data || cyc - e.acc != 5) begin
        failures++;
        $display("FAIL abort_data: got %h lat %0d exp %h lat 5", rsp0_data, cyc - e.acc, e.data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 37 + 11);
    mem[16] = 8'h13;
    mem[17] = 8'h05;
    mem[18] = 8'h50;
    mem[19] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_fetch_arbiter.md
IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the byte-address width of the instruction memory (2**ADDR_WIDTH bytes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  port 0 (CPU fetch) requests a 32-bit instruction read.
REQ-005 req0_addr  input  32  port 0 byte address.
REQ-006 req0_ready  output  1  port 0 request accepted this cycle.
REQ-007 rsp0_valid  output  1  port 0 response word available.
REQ-008 rsp0_ready  input  1  port 0 consumes response.
REQ-009 rsp0_data  output  32  port 0 instruction word.
REQ-010 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_ready, rsp1_data SHALL mirror REQ-004..REQ-009 for port 1 (debug/loader read).
REQ-011 mem_en  output  1  byte read strobe to the byte-wide instruction memory.
REQ-012 mem_addr  output  ADDR_WIDTH  byte address for mem_en.
REQ-013 mem_rdata  input  8  byte read data, valid the cycle after mem_en (synchronous read, 1-cycle latency).
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, READ, DRAIN, RESP; a 2-bit counter cnt SHALL index bytes 0..3 in READ.
REQ-016 IDLE: if exactly one reqN_valid is high, that port SHALL be granted; if both are high, the port not granted last SHALL be granted (round-robin, last_grant register).
REQ-017 reqN_ready SHALL be combinational, high only in IDLE for the granted port; handshake = reqN_valid & reqN_ready.
REQ-018 On handshake the block SHALL latch base = {reqN_addr[ADDR_WIDTH-1:2], 2'b00}, record the port, update last_grant, clear cnt, and enter READ.
REQ-019 Address bits [1:0] and bits above ADDR_WIDTH-1 SHALL be ignored; later changes to reqN_addr SHALL have no effect on the transaction in flight.
REQ-020 READ: mem_en=1, mem_addr=base+cnt; cnt increments each cycle; after cnt=3 the state SHALL go to DRAIN.
REQ-021 Outside READ, mem_en=0 and mem_addr=0.
REQ-022 The byte returned for offset k SHALL be captured at the edge after it is issued into data bits [31-8k:24-8k] (offset 0 = MSB, offset 3 = LSB).
REQ-023 DRAIN: capture of offset 3 completes; next state RESP.
REQ-024 RESP: rspN_valid=1 for the recorded port only, rspN_data = assembled word held stable; on rspN_ready the state SHALL return to IDLE.
REQ-025 Latency: rspN_valid SHALL rise exactly 5 clock edges after the accepting edge; minimum issue interval 6 cycles per transaction (7 with an IDLE cycle).
REQ-026 The non-granted port SHALL see reqN_ready=0 and rspN_valid=0 for the whole transaction; its request stays pending with no loss.
REQ-027 A requester dropping reqN_valid before handshake SHALL cause no state change.
REQ-028 rspN_data SHALL hold its last value after the handshake until the next capture for that port.

Reset
REQ-029 While rst=0: state IDLE, cnt=0, base=0, mem_en=0, mem_addr=0, busy=0, req0/1_ready=0, rsp0/1_valid=0, rsp0/1_data=0, last_grant=1 (port 0 wins the first tie).
REQ-030 Reset asserted mid-transaction SHALL abort immediately with no response issued; after deassertion the block SHALL accept new requests from IDLE on the first edge.

Verification
REQ-031 Memory bytes 0x10..0x13 = 13,05,50,00; port 0 request addr 0x10, rsp0_ready=1 -> mem_addr 0x10..0x13 on 4 consecutive cycles, rsp0_valid 5 edges after accept, rsp0_data=0x13055000.
REQ-032 Port 0 addr 0x13 and addr 0xFFFF_FC10 (ADDR_WIDTH=10) -> both read base 0x010, same data as REQ-031.
REQ-033 Both ports valid continuously, addresses 0x00 and 0x04 -> grants alternate 0,1,0,1; each rspN_data matches its own address; no response on wrong port.
REQ-034 rsp1_ready held low 10 cycles in RESP -> rsp1_valid and rsp1_data stable, mem_en=0, req0_ready=0 throughout; release -> IDLE next edge.
REQ-035 rst pulsed low during READ cnt=2 -> all outputs reset values immediately, no rsp_valid; new request after release completes with correct data.
